// File: rtl/pixel_ctrl_pkg.sv
// Shared types and defaults for the pixel array frame sequencer, its row scanner and the benches.
package pixel_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPwrup,
    StErase,
    StExpose,
    StConvert,
    StReadout
  } pixel_state_e;

  localparam int unsigned PIX_DATA_W   = 8;
  localparam int unsigned PIX_NUM_ROWS = 2;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pixel_row_scanner.sv
// Readout row walker: one-hot select plus binary index, advanced by the READ_READY handshake.
module pixel_row_scanner
  import pixel_ctrl_pkg::*;
#(
  parameter int unsigned NUM_ROWS = PIX_NUM_ROWS,
  parameter int unsigned ROW_W    = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic                read_ready,
  output logic                row_valid,
  output logic [NUM_ROWS-1:0] row_sel,
  output logic [ROW_W-1:0]    row_idx,
  output logic                last_accept
);

  logic                valid_q, valid_d;
  logic [NUM_ROWS-1:0] sel_q, sel_d;
  logic [ROW_W-1:0]    idx_q, idx_d;
  logic                accept;
  logic                at_last;

  assign accept      = valid_q & read_ready;
  assign at_last     = (idx_q == ROW_W'(NUM_ROWS - 1));
  assign last_accept = accept & at_last;

  always_comb begin
    valid_d = valid_q;
    sel_d   = sel_q;
    idx_d   = idx_q;
    if (load) begin
      valid_d = 1'b1;
      sel_d   = NUM_ROWS'(1);
      idx_d   = '0;
    end else if (accept) begin
      if (at_last) begin
        valid_d = 1'b0;
        sel_d   = '0;
        idx_d   = '0;
      end else begin
        sel_d = sel_q << 1;
        idx_d = idx_q + ROW_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      sel_q   <= '0;
      idx_q   <= '0;
    end else begin
      valid_q <= valid_d;
      sel_q   <= sel_d;
      idx_q   <= idx_d;
    end
  end

  assign row_valid = valid_q;
  assign row_sel   = sel_q;
  assign row_idx   = idx_q;

endmodule

// File: rtl/pixel_array_controller.sv
// Frame sequencer for the pixel array: power-up, erase, exposure, ramp conversion, row readout.
// Optional PIXEL_CTRL_AUTO_RESTART_EN adds CONTINUOUS for back-to-back frames without IDLE.
module pixel_array_controller
  import pixel_ctrl_pkg::*;
#(
  parameter int unsigned NUM_ROWS     = PIX_NUM_ROWS,
  parameter int unsigned ROW_W        = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1,
  parameter int unsigned PWRUP_CYCLES = 4,
  parameter int unsigned ERASE_CYCLES = 5,
  parameter int unsigned EXP_W        = 16,
  parameter int unsigned DATA_W       = PIX_DATA_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                START,
  input  logic [EXP_W-1:0]    EXPOSE_TIME,
  input  logic                READ_READY,
`ifdef PIXEL_CTRL_AUTO_RESTART_EN
  input  logic                CONTINUOUS,
`endif
  output logic                POWER_ENABLE,
  output logic                PIXEL_RESET,
  output logic                ERASE,
  output logic                EXPOSE,
  output logic                COUNTER_RESET,
  output logic                COUNTER_EN,
  output logic                WRITE_ENABLE,
  output logic [NUM_ROWS-1:0] ROW_SEL,
  output logic [ROW_W-1:0]    ROW_IDX,
  output logic                ROW_VALID,
  output logic                BUSY,
  output logic                FRAME_DONE
);

  localparam int unsigned CNT_W = max_u(EXP_W, DATA_W + 1);
  // Conversion is one counter-clear cycle followed by 2^DATA_W counting cycles.
  localparam logic [CNT_W-1:0] CONV_LOAD  = CNT_W'(1) << DATA_W;
  localparam logic [CNT_W-1:0] PWRUP_LOAD = CNT_W'(PWRUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] ERASE_LOAD = CNT_W'(ERASE_CYCLES - 1);

  pixel_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [EXP_W-1:0] exp_q, exp_d;
  logic [CNT_W-1:0] expose_load;
  logic             restart;
  logic             scan_load;
  logic             last_accept;

  logic power_q, power_d;
  logic erase_q, erase_d;
  logic expose_q, expose_d;
  logic cnt_reset_q, cnt_reset_d;
  logic cnt_en_q, cnt_en_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

`ifdef PIXEL_CTRL_AUTO_RESTART_EN
  assign restart = CONTINUOUS;
`else
  assign restart = 1'b0;
`endif

  // A zero exposure still gets one EXPOSE cycle.
  assign expose_load = (exp_q == '0) ? '0 : (CNT_W'(exp_q) - CNT_W'(1));
  assign scan_load   = (state_q == StConvert) && (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    exp_d   = exp_q;
    case (state_q)
      StIdle: begin
        if (START) begin
          state_d = StPwrup;
          cnt_d   = PWRUP_LOAD;
          exp_d   = EXPOSE_TIME;
        end
      end
      StPwrup: begin
        if (cnt_q == '0) begin
          state_d = StErase;
          cnt_d   = ERASE_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      StErase: begin
        if (cnt_q == '0) begin
          state_d = StExpose;
          cnt_d   = expose_load;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      StExpose: begin
        if (cnt_q == '0) begin
          state_d = StConvert;
          cnt_d   = CONV_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      StConvert: begin
        if (cnt_q == '0) begin
          state_d = StReadout;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      StReadout: begin
        if (last_accept) begin
          if (restart) begin
            state_d = StErase;
            cnt_d   = ERASE_LOAD;
          end else begin
            state_d = StIdle;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Strobes are decoded from the next state so every output leaves a flop.
  always_comb begin
    power_d     = (state_d != StIdle);
    busy_d      = (state_d != StIdle);
    erase_d     = (state_d == StErase);
    expose_d    = (state_d == StExpose);
    cnt_reset_d = (state_d == StConvert) && (cnt_d == CONV_LOAD);
    cnt_en_d    = (state_d == StConvert) && (cnt_d != CONV_LOAD);
    done_d      = (state_q == StReadout) && last_accept;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      exp_q       <= '0;
      power_q     <= 1'b0;
      erase_q     <= 1'b0;
      expose_q    <= 1'b0;
      cnt_reset_q <= 1'b0;
      cnt_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      exp_q       <= exp_d;
      power_q     <= power_d;
      erase_q     <= erase_d;
      expose_q    <= expose_d;
      cnt_reset_q <= cnt_reset_d;
      cnt_en_q    <= cnt_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  pixel_row_scanner #(
    .NUM_ROWS (NUM_ROWS),
    .ROW_W    (ROW_W)
  ) u_row_scanner (
    .clk         (clk),
    .reset       (reset),
    .load        (scan_load),
    .read_ready  (READ_READY),
    .row_valid   (ROW_VALID),
    .row_sel     (ROW_SEL),
    .row_idx     (ROW_IDX),
    .last_accept (last_accept)
  );

  assign POWER_ENABLE  = power_q;
  assign PIXEL_RESET   = erase_q;
  assign ERASE         = erase_q;
  assign EXPOSE        = expose_q;
  assign COUNTER_RESET = cnt_reset_q;
  assign COUNTER_EN    = cnt_en_q;
  assign WRITE_ENABLE  = cnt_en_q;
  assign BUSY          = busy_q;
  assign FRAME_DONE    = done_q;

endmodule

// File: doc/pixel_array_controller.md
Name: pixel_array_controller

Overview:
Frame sequencer for the PIXEL_ARRAY digital pixel sensor block. It runs each frame through power-up, erase, exposure, ramp conversion and row-by-row readout. In each phase it drives the array's control strobes, counter reset/enable and write-enable. It sits between the top-level capture logic (START / READ_READY) and the PIXEL_ARRAY instance, all on one system clock.

Parameters:
NUM_ROWS, 2, number of pixel rows read out one at a time.
ROW_W, $clog2(NUM_ROWS) (min 1), width of ROW_IDX.
PWRUP_CYCLES, 4, cycles POWER_ENABLE is held before ERASE.
ERASE_CYCLES, 5, cycles ERASE is asserted.
EXP_W, 16, width of EXPOSE_TIME.
DATA_W, 8, pixel counter width; conversion lasts 2^DATA_W cycles.

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low; clears all state
START  in  1  request a frame; sampled only in IDLE
EXPOSE_TIME  in  EXP_W  exposure length in cycles; captured on the accepted START
READ_READY  in  1  downstream accepts the current row
POWER_ENABLE  out  1  array analog power
PIXEL_RESET  out  1  pixel reset strobe (array RESET)
ERASE  out  1  array ERASE
EXPOSE  out  1  array EXPOSE
COUNTER_RESET  out  1  one-cycle clear of the Gray/ramp counter
COUNTER_EN  out  1  counter clock enable
WRITE_ENABLE  out  1  array pixel-memory write enable
ROW_SEL  out  NUM_ROWS  one-hot read select
ROW_IDX  out  ROW_W  binary index of the selected row
ROW_VALID  out  1  ROW_SEL/ROW_IDX valid for readout
BUSY  out  1  high in any state other than IDLE
FRAME_DONE  out  1  one-cycle pulse after the last row is accepted

Behaviour:
- All outputs are registered. When reset is low, the FSM goes to IDLE and every output is 0.
- States: IDLE -> PWRUP -> ERASE -> EXPOSE -> CONVERT -> READOUT -> IDLE. A down-counter (max(EXP_W, DATA_W+1) bits) is loaded on each state entry.
- IDLE: every output is 0. START=1 captures EXPOSE_TIME and moves to PWRUP on the next edge. START is ignored in all other states; there is no queuing.
- PWRUP: POWER_ENABLE=1 for PWRUP_CYCLES cycles. POWER_ENABLE stays 1 through READOUT and drops on the return to IDLE.
- ERASE: ERASE=1 and PIXEL_RESET=1 for ERASE_CYCLES cycles.
- EXPOSE: EXPOSE=1 for the captured EXPOSE_TIME cycles. A value of 0 is treated as 1.
- CONVERT:
  - First cycle: COUNTER_RESET=1 and COUNTER_EN=0.
  - Next 2^DATA_W cycles: COUNTER_EN=1 and WRITE_ENABLE=1.
  - Last cycle: WRITE_ENABLE drops to 0 together with the state exit, which freezes the pixel memories.
  - Total CONVERT duration is 2^DATA_W+1 cycles.
- READOUT:
  - ROW_VALID=1, ROW_SEL = 1<<ROW_IDX, starting at row 0.
  - A row advances only on a cycle where ROW_VALID and READ_READY are both 1. ROW_SEL holds while READ_READY=0; the stall is unbounded.
  - Acceptance of row NUM_ROWS-1 gives IDLE on the next edge and FRAME_DONE=1 for exactly that one cycle.
- Only one control strobe is active at a time, with no overlap on transitions: ERASE, EXPOSE, COUNTER_EN and ROW_VALID are mutually exclusive.
- If reset is asserted mid-frame, all outputs go to 0 immediately (asynchronously) and the FSM returns to IDLE. No partial FRAME_DONE is generated.
- Exposure counter arithmetic is unsigned and cannot wrap; the maximum exposure is 2^EXP_W-1 cycles.

Optional Feature:
- Macro: PIXEL_CTRL_AUTO_RESTART_EN.
- With the macro defined: an extra input CONTINUOUS (1 bit) is added. If CONTINUOUS=1 at the last row acceptance, the FSM goes directly to ERASE, skipping IDLE and PWRUP. It reuses the captured EXPOSE_TIME, keeps POWER_ENABLE and BUSY high, and still pulses FRAME_DONE.
- Without the macro: the CONTINUOUS port does not exist and every frame ends in IDLE.

Decomposition:
- Shared package pixel_ctrl_pkg: state enum typedef (IDLE, PWRUP, ERASE, EXPOSE, CONVERT, READOUT) and default-parameter localparams (DATA_W, NUM_ROWS), shared with PIXEL_ARRAY and the benches.
- One natural sub-module, pixel_row_scanner: the READOUT one-hot/index generator with its READ_READY handshake and last-row flag.

Test Plan:
- reset low mid-EXPOSE -> all outputs 0 the same cycle; after release, BUSY=0 and START is required again.
- START with EXPOSE_TIME=10, READ_READY tied 1, defaults -> POWER_ENABLE 4 cycles before ERASE; ERASE 5 cycles; EXPOSE 10 cycles; COUNTER_RESET 1 cycle; COUNTER_EN/WRITE_ENABLE 256 cycles; ROW_SEL 01 then 10; FRAME_DONE one pulse; total 279 cycles START->IDLE.
- EXPOSE_TIME=0 -> EXPOSE high exactly 1 cycle.
- READ_READY held 0 for 20 cycles on row 0 -> ROW_SEL=01 and ROW_VALID stable; row advances only on the first cycle READ_READY=1.
- START pulsed during CONVERT -> ignored; exactly one FRAME_DONE.
- PIXEL_CTRL_AUTO_RESTART_EN with CONTINUOUS=1 -> ERASE follows the last row acceptance on the next cycle; POWER_ENABLE never drops; two FRAME_DONE pulses for two frames.
